// File: rtl/pio_edge_master.sv
// rtl/pio_edge_master.sv - Edge-capture PIO service master.
// Programs the interrupt mask, then reads, clears and forwards the captured edge bits.
module pio_edge_master #(
  parameter int WIDTH     = 4,
  parameter int MASK_ADDR = 2,
  parameter int EDGE_ADDR = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [1:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  input  logic             avm_waitrequest,
  input  logic             irq,
  input  logic [WIDTH-1:0] mask_cfg,
  output logic             evt_valid,
  output logic [WIDTH-1:0] evt_bits,
  input  logic             evt_ready,
  output logic             busy
);

  localparam logic [2:0] S_INIT_MASK = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_RD_EDGE   = 3'd2;
  localparam logic [2:0] S_RD_DATA   = 3'd3;
  localparam logic [2:0] S_CLR_EDGE  = 3'd4;
  localparam logic [2:0] S_EVENT     = 3'd5;

  localparam logic [1:0] MASK_A = MASK_ADDR[1:0];
  localparam logic [1:0] EDGE_A = EDGE_ADDR[1:0];

  logic [2:0]       state;
  logic [2:0]       state_nx;
  logic [WIDTH-1:0] shadow_mask;
  logic [WIDTH-1:0] wdata_q;
  logic             accept;
  logic             unused_rd;

  assign accept        = avm_chipselect && !avm_waitrequest;
  assign busy          = (state != S_IDLE);
  assign avm_writedata = {{(32-WIDTH){1'b0}}, wdata_q};
  assign unused_rd     = ^avm_readdata[31:WIDTH];

  always_comb begin
    state_nx = state;
    case (state)
      S_INIT_MASK: if (accept) state_nx = S_IDLE;
      S_IDLE: begin
        if (mask_cfg != shadow_mask) state_nx = S_INIT_MASK;
        else if (irq)                state_nx = S_RD_EDGE;
      end
      S_RD_EDGE:  if (accept) state_nx = S_RD_DATA;
      S_RD_DATA:  state_nx = (avm_readdata[WIDTH-1:0] != '0) ? S_CLR_EDGE : S_IDLE;
      S_CLR_EDGE: if (accept) state_nx = S_EVENT;
      S_EVENT:    if (evt_ready) state_nx = S_IDLE;
      default:    state_nx = S_INIT_MASK;
    endcase
  end

  // Bus outputs are registered from the next state, so they always mirror the
  // current state and hold naturally while a transfer is stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_INIT_MASK;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_address    <= 2'd0;
      wdata_q        <= '0;
      evt_valid      <= 1'b0;
      evt_bits       <= '0;
      shadow_mask    <= '0;
    end else begin
      state     <= state_nx;
      evt_valid <= (state_nx == S_EVENT);
      if (state == S_INIT_MASK && accept) shadow_mask <= wdata_q;
      if (state == S_RD_DATA) evt_bits <= avm_readdata[WIDTH-1:0];
      case (state_nx)
        S_INIT_MASK: begin
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
          avm_address    <= MASK_A;
          // Sample the mask only when the write is first launched, never mid-stall.
          if (!avm_chipselect) wdata_q <= mask_cfg;
        end
        S_RD_EDGE: begin
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b1;
          avm_address    <= EDGE_A;
          wdata_q        <= '0;
        end
        S_CLR_EDGE: begin
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
          avm_address    <= EDGE_A;
          wdata_q        <= '0;
        end
        default: begin
          avm_chipselect <= 1'b0;
          avm_write_n    <= 1'b1;
          avm_address    <= 2'd0;
          wdata_q        <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pio_edge_master.sv
// tb/tb_pio_edge_master.sv - Self-checking bench for pio_edge_master with a behavioural PIO slave.
module tb_pio_edge_master;
  localparam int WIDTH = 4;
  localparam logic [1:0] MASK_A = 2'd2;
  localparam logic [1:0] EDGE_A = 2'd3;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [1:0]       avm_address;
  logic             avm_chipselect;
  logic             avm_write_n;
  logic [31:0]      avm_writedata;
  logic [31:0]      avm_readdata = 32'd0;
  logic             avm_waitrequest = 1'b0;
  logic             irq = 1'b0;
  logic [WIDTH-1:0] mask_cfg = 4'b0101;
  logic             evt_valid;
  logic [WIDTH-1:0] evt_bits;
  logic             evt_ready = 1'b1;
  logic             busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pio_edge_master #(.WIDTH(WIDTH), .MASK_ADDR(2), .EDGE_ADDR(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .irq(irq), .mask_cfg(mask_cfg), .evt_valid(evt_valid), .evt_bits(evt_bits),
    .evt_ready(evt_ready), .busy(busy)
  );

  // Slave model: edge and mask registers, programmable stalls, transaction log.
  logic [WIDTH-1:0] edge_reg = '0;
  logic [WIDTH-1:0] mask_reg = '0;
  logic [WIDTH-1:0] rd_value = '0;
  int               stall_rd = 0;
  int               stall_wr = 0;
  int               stall_cnt = 0;
  int               unstable = 0;
  logic             rd_pending = 1'b0;
  logic             last_wait = 1'b0;
  logic             last_cs = 1'b0;
  logic             last_wn = 1'b1;
  logic [1:0]       last_addr = 2'd0;
  logic [31:0]      last_wd = 32'd0;
  logic [1:0]       q_addr[$];
  logic             q_wr[$];
  logic [31:0]      q_data[$];

  always @(negedge clk) begin
    avm_readdata = $urandom;
    if (rd_pending) avm_readdata[WIDTH-1:0] = rd_value;
    rd_pending = 1'b0;
    if (!reset_n) begin
      avm_waitrequest = 1'b0;
      stall_cnt = 0;
      last_wait = 1'b0;
    end else begin
      if (last_wait && (avm_chipselect !== last_cs || avm_address !== last_addr ||
                        avm_write_n !== last_wn || avm_writedata !== last_wd))
        unstable++;
      if (avm_chipselect === 1'b1) begin
        if (stall_cnt < (avm_write_n ? stall_rd : stall_wr)) begin
          avm_waitrequest = 1'b1;
          stall_cnt++;
        end else begin
          avm_waitrequest = 1'b0;
          stall_cnt = 0;
          q_addr.push_back(avm_address);
          q_wr.push_back(!avm_write_n);
          q_data.push_back(avm_writedata);
          if (!avm_write_n) begin
            if (avm_address == EDGE_A) edge_reg = '0;
            if (avm_address == MASK_A) mask_reg = avm_writedata[WIDTH-1:0];
          end else begin
            rd_pending = 1'b1;
            rd_value = edge_reg;
          end
        end
      end else begin
        avm_waitrequest = 1'($urandom_range(0, 1));
        stall_cnt = 0;
      end
      last_cs = avm_chipselect;
      last_addr = avm_address;
      last_wn = avm_write_n;
      last_wd = avm_writedata;
      last_wait = avm_chipselect && avm_waitrequest;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
  endtask

  // Stimulus only: raise irq with the given edge bits and stalls, observe the event.
  task automatic run_event(input logic [WIDTH-1:0] bits, input int srd, input int swr,
                           output int lat, output logic [WIDTH-1:0] got, output int nvalid,
                           output int qb);
    int n;
    edge_reg = bits;
    stall_rd = srd;
    stall_wr = swr;
    qb = q_addr.size();
    irq = 1'b1;
    lat = 0;
    while (evt_valid !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    irq = 1'b0;
    got = evt_bits;
    nvalid = 0;
    while (evt_valid === 1'b1 && nvalid < 100) begin
      nvalid++;
      tick();
    end
    wait_idle(n);
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (avm_chipselect !== 1'b0) begin errors++; $display("FAIL reset_cs: got %b want 0", avm_chipselect); end
    checks++; if (avm_write_n !== 1'b1) begin errors++; $display("FAIL reset_write_n: got %b want 1", avm_write_n); end
    checks++; if (avm_address !== 2'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", avm_address); end
    checks++; if (avm_writedata !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h want 0", avm_writedata); end
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_evt_valid: got %b want 0", evt_valid); end
    checks++; if (evt_bits !== 4'd0) begin errors++; $display("FAIL reset_evt_bits: got %h want 0", evt_bits); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
  endtask

  task automatic test_init_mask();
    int n;
    int qb;
    qb = q_addr.size();
    reset_n = 1'b1;
    wait_idle(n);
    checks++; if (n != 2) begin errors++; $display("FAIL init_latency: got %0d want 2", n); end
    checks++; if (q_addr.size() - qb != 1) begin errors++; $display("FAIL init_count: got %0d want 1", q_addr.size() - qb); end
    checks++; if (q_wr[qb] !== 1'b1 || q_addr[qb] !== MASK_A) begin errors++; $display("FAIL init_target: got wr=%b addr=%0d want wr=1 addr=2", q_wr[qb], q_addr[qb]); end
    checks++; if (q_data[qb] !== 32'h5) begin errors++; $display("FAIL init_data: got %h want 00000005", q_data[qb]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL init_busy: got %b want 0", busy); end
  endtask

  task automatic test_event_basic();
    int lat, nv, qb;
    logic [WIDTH-1:0] got;
    run_event(4'b0010, 0, 0, lat, got, nv, qb);
    checks++; if (lat != 4) begin errors++; $display("FAIL basic_latency: got %0d want 4", lat); end
    checks++; if (got !== 4'b0010) begin errors++; $display("FAIL basic_bits: got %b want 0010", got); end
    checks++; if (nv != 1) begin errors++; $display("FAIL basic_valid_cycles: got %0d want 1", nv); end
    checks++; if (q_addr.size() - qb != 2) begin errors++; $display("FAIL basic_count: got %0d want 2", q_addr.size() - qb); end
    checks++; if (q_wr[qb] !== 1'b0 || q_addr[qb] !== EDGE_A) begin errors++; $display("FAIL basic_read: got wr=%b addr=%0d want wr=0 addr=3", q_wr[qb], q_addr[qb]); end
    checks++; if (q_wr[qb+1] !== 1'b1 || q_addr[qb+1] !== EDGE_A || q_data[qb+1] !== 32'd0) begin errors++; $display("FAIL basic_clear: got wr=%b addr=%0d data=%h want wr=1 addr=3 data=0", q_wr[qb+1], q_addr[qb+1], q_data[qb+1]); end
  endtask

  task automatic test_random_events();
    int lat, nv, qb, srd, swr;
    logic [WIDTH-1:0] bits, got;
    for (int i = 0; i < 8; i++) begin
      bits = 4'($urandom_range(1, 15));
      srd = $urandom_range(0, 3);
      swr = $urandom_range(0, 3);
      run_event(bits, srd, swr, lat, got, nv, qb);
      checks++; if (lat != 4 + srd + swr) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, 4 + srd + swr); end
      checks++; if (got !== bits) begin errors++; $display("FAIL rand_bits[%0d]: got %b want %b", i, got, bits); end
      checks++; if (nv != 1) begin errors++; $display("FAIL rand_valid_cycles[%0d]: got %0d want 1", i, nv); end
      checks++; if (q_addr.size() - qb != 2 || q_wr[qb+1] !== 1'b1) begin errors++; $display("FAIL rand_txns[%0d]: got %0d txns want read+clear", i, q_addr.size() - qb); end
    end
  endtask

  task automatic test_stall();
    int lat, nv, qb;
    logic [WIDTH-1:0] bits, got;
    bits = 4'($urandom_range(1, 15));
    unstable = 0;
    run_event(bits, 3, 2, lat, got, nv, qb);
    stall_rd = 0;
    stall_wr = 0;
    checks++; if (unstable != 0) begin errors++; $display("FAIL stall_stability: got %0d changes want 0", unstable); end
    checks++; if (lat != 9) begin errors++; $display("FAIL stall_latency: got %0d want 9", lat); end
    checks++; if (got !== bits) begin errors++; $display("FAIL stall_bits: got %b want %b", got, bits); end
  endtask

  task automatic test_spurious();
    int n, nval, qb;
    edge_reg = '0;
    qb = q_addr.size();
    irq = 1'b1;
    n = 0;
    while (avm_chipselect !== 1'b1 && n < 100) begin tick(); n++; end
    irq = 1'b0;
    checks++; if (n >= 100) begin errors++; $display("FAIL spur_read_issued: got timeout want read"); end
    nval = 0;
    repeat (6) begin tick(); if (evt_valid === 1'b1) nval++; end
    checks++; if (q_addr.size() - qb != 1 || q_wr[qb] !== 1'b0) begin errors++; $display("FAIL spur_txns: got %0d txns want a single read", q_addr.size() - qb); end
    checks++; if (nval != 0) begin errors++; $display("FAIL spur_evt_valid: got %0d cycles want 0", nval); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL spur_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_backpressure();
    int n, qb, bad;
    logic [WIDTH-1:0] bits;
    bits = 4'($urandom_range(1, 15));
    edge_reg = bits;
    evt_ready = 1'b0;
    qb = q_addr.size();
    irq = 1'b1;
    n = 0;
    while (evt_valid !== 1'b1 && n < 100) begin tick(); n++; end
    checks++; if (n != 4) begin errors++; $display("FAIL bp_latency: got %0d want 4", n); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) mask_cfg = 4'b1111;
      if (evt_valid !== 1'b1 || evt_bits !== bits) bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
    evt_ready = 1'b1;
    tick();
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL bp_drop: got %b want 0", evt_valid); end
    n = 0;
    while (q_addr.size() < qb + 4 && n < 100) begin tick(); n++; end
    irq = 1'b0;
    checks++; if (q_wr[qb+2] !== 1'b1 || q_addr[qb+2] !== MASK_A || q_data[qb+2] !== 32'hF) begin errors++; $display("FAIL bp_mask_first: got wr=%b addr=%0d data=%h want wr=1 addr=2 data=f", q_wr[qb+2], q_addr[qb+2], q_data[qb+2]); end
    checks++; if (q_wr[qb+3] !== 1'b0 || q_addr[qb+3] !== EDGE_A) begin errors++; $display("FAIL bp_read_after: got wr=%b addr=%0d want wr=0 addr=3", q_wr[qb+3], q_addr[qb+3]); end
    wait_idle(n);
    checks++; if (mask_reg !== 4'hF || busy !== 1'b0) begin errors++; $display("FAIL bp_final: got mask=%h busy=%b want mask=f busy=0", mask_reg, busy); end
  endtask

  // phase 0: reset while in RD_DATA; phase 1: reset during a stalled clear write.
  task automatic test_reset_mid(input int phase);
    int n, qb;
    logic [WIDTH-1:0] m;
    edge_reg = 4'($urandom_range(1, 15));
    stall_rd = 0;
    stall_wr = (phase == 1) ? 5 : 0;
    irq = 1'b1;
    n = 0;
    if (phase == 0) begin
      while (!(avm_chipselect === 1'b1 && avm_waitrequest === 1'b0 && avm_write_n === 1'b1) && n < 100) begin tick(); n++; end
    end else begin
      while (!(avm_chipselect === 1'b1 && avm_write_n === 1'b0 && avm_address === EDGE_A) && n < 100) begin tick(); n++; end
    end
    irq = 1'b0;
    tick();
    checks++; if (n >= 100) begin errors++; $display("FAIL mid%0d_reach: got timeout want target state", phase); end
    reset_n = 1'b0;
    #1;
    checks++; if (avm_chipselect !== 1'b0 || avm_write_n !== 1'b1 || avm_address !== 2'd0 || avm_writedata !== 32'd0) begin errors++; $display("FAIL mid%0d_bus: got cs=%b wn=%b addr=%0d wd=%h want 0 1 0 0", phase, avm_chipselect, avm_write_n, avm_address, avm_writedata); end
    checks++; if (evt_valid !== 1'b0 || evt_bits !== 4'd0 || busy !== 1'b1) begin errors++; $display("FAIL mid%0d_evt: got valid=%b bits=%h busy=%b want 0 0 1", phase, evt_valid, evt_bits, busy); end
    tick();
    edge_reg = '0;
    stall_wr = 0;
    m = 4'($urandom_range(0, 15));
    mask_cfg = m;
    qb = q_addr.size();
    reset_n = 1'b1;
    wait_idle(n);
    checks++; if (q_addr.size() - qb != 1 || q_addr[qb] !== MASK_A || q_wr[qb] !== 1'b1 || q_data[qb] !== {28'd0, m}) begin errors++; $display("FAIL mid%0d_reinit: got %0d txns addr=%0d data=%h want 1 mask write of %h", phase, q_addr.size() - qb, q_addr[qb], q_data[qb], m); end
  endtask

  initial begin
    test_reset();
    test_init_mask();
    test_event_basic();
    test_random_events();
    test_stall();
    test_spurious();
    test_backpressure();
    test_reset_mid(0);
    test_reset_mid(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
